// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Sequencing FSM for a multi-cycle RV32I-subset core sharing one
//            memory port, with a memory-response watchdog. Define
//            PERF_COUNTERS_EN to add cycle_count/instret ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic [2:0]  imm_src,
  output logic [1:0]  result_src,
  output logic        illegal,
  output logic        halted,
  output logic [3:0]  state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
`endif
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_EXEC_I = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_JALR   = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_HALT   = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

  logic [3:0] r_state, w_next;
  logic [7:0] r_wdog;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_bad;
  logic       w_wait_state;
  logic       w_timeout;
  logic       w_unused_bits;

  assign w_opcode      = instr[6:0];
  assign w_funct3      = instr[14:12];
  assign w_funct7      = instr[31:25];
  assign w_unused_bits = &{1'b0, instr[24:15], instr[11:7]};

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // mem_ready takes priority over an expiring watchdog on the same cycle
  assign w_timeout    = !mem_ready && (r_wdog == C_TIMEOUT);

  always_comb begin
    w_bad = 1'b0;
    case (w_opcode)
      OP_OP:     w_bad = (w_funct3 != 3'b000) || (w_funct7 != 7'd0);
      OP_OPIMM:  w_bad = (w_funct3 != 3'b000);
      OP_LOAD:   w_bad = (w_funct3 != 3'b100);
      OP_STORE:  w_bad = (w_funct3 != 3'b000);
      OP_BRANCH: w_bad = (w_funct3 != 3'b001) && (w_funct3 != 3'b111);
      OP_JALR:   w_bad = (w_funct3 != 3'b000);
      OP_LUI,
      OP_JAL:    w_bad = 1'b0;
      default:   w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_wdog <= 8'd0;
    else if (w_wait_state && !mem_ready && !w_timeout) r_wdog <= r_wdog + 8'd1;
    else                                        r_wdog <= 8'd0;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : (w_timeout ? S_HALT : S_FETCH);
      S_DECODE: begin
        if (w_bad) w_next = S_FETCH;
        else begin
          case (w_opcode)
            OP_LOAD, OP_STORE: w_next = S_MEMADR;
            OP_OP:             w_next = S_EXEC_R;
            OP_OPIMM, OP_LUI:  w_next = S_EXEC_I;
            OP_BRANCH:         w_next = S_BRANCH;
            OP_JAL:            w_next = S_JAL;
            OP_JALR:           w_next = S_JALR;
            default:           w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: w_next = (w_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : (w_timeout ? S_HALT : S_MEMRD);
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : (w_timeout ? S_HALT : S_MEMWR);
      S_EXEC_R,
      S_EXEC_I: w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JAL,
      S_JALR:   w_next = S_JUMP;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    imm_src     = 3'b000;
    result_src  = 2'b00;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        illegal   = w_bad;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (w_opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC_R: alu_src_a = 2'b10;
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (w_opcode == OP_LUI) begin
          imm_src     = 3'b011;
          alu_control = 3'b010;
        end
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        // bne: sub, taken on nonzero; bgeu: sltu, taken when rs1<rs2 is false
        if (w_funct3 == 3'b111) begin
          alu_control = 3'b011;
          pc_write    = alu_zero;
        end else begin
          alu_control = 3'b001;
          pc_write    = !alu_zero;
        end
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        imm_src    = 3'b100;
        reg_write  = 1'b1;
        result_src = 2'b11;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        reg_write  = 1'b1;
        result_src = 2'b11;
      end
      S_JUMP: pc_write = 1'b1;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

`ifdef PERF_COUNTERS_EN
  logic [31:0] r_cycle_count, r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_count <= 32'd0;
      r_instret     <= 32'd0;
    end else begin
      if (r_state != S_HALT) r_cycle_count <= r_cycle_count + 32'd1;
      if ((w_next == S_FETCH) && (r_state != S_FETCH)) r_instret <= r_instret + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instret     = r_instret;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences, memory waits,
// mid-instruction reset, illegal decode and watchdog halt.
`default_nettype none

module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [31:0] instr;
  logic        alu_zero, mem_ready;
  logic        wd_ready;

  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, illegal, halted;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_control, imm_src;
  logic [3:0]  state;

  logic        w2_mem_req, w2_mem_we, w2_iord, w2_ir_write, w2_pc_write, w2_reg_write;
  logic        w2_illegal, w2_halted;
  logic [1:0]  w2_alu_src_a, w2_alu_src_b, w2_result_src;
  logic [2:0]  w2_alu_control, w2_imm_src;
  logic [3:0]  w2_state;

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret, w2_cycle_count, w2_instret;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .result_src(result_src), .illegal(illegal), .halted(halted), .state(state)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret(instret)
`endif
  );

  multicycle_controller #(.MEM_TIMEOUT(4)) dut_wd (
    .clk(clk), .rst(rst2), .instr(instr), .alu_zero(alu_zero), .mem_ready(wd_ready),
    .mem_req(w2_mem_req), .mem_we(w2_mem_we), .iord(w2_iord), .ir_write(w2_ir_write),
    .pc_write(w2_pc_write), .reg_write(w2_reg_write), .alu_src_a(w2_alu_src_a),
    .alu_src_b(w2_alu_src_b), .alu_control(w2_alu_control), .imm_src(w2_imm_src),
    .result_src(w2_result_src), .illegal(w2_illegal), .halted(w2_halted), .state(w2_state)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(w2_cycle_count), .instret(w2_instret)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit stayed;
    rst = 1'b1; rst2 = 1'b1; wd_ready = 1'b0;
    instr = 32'h0; alu_zero = 1'b0; mem_ready = 1'b0;
    cyc(); cyc();

    // reset values
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd1);
    check("rst_iord", 32'(iord), 32'd0);
    check("rst_strobes", 32'({ir_write, pc_write, reg_write, mem_we, illegal, halted}), 32'd0);

    // add x3,x1,x2 with zero-wait memory
    rst = 1'b0; instr = 32'h002081B3; mem_ready = 1'b1; #1;
    check("add_fetch_irw_pcw", 32'({ir_write, pc_write}), 32'b11);
    check("add_fetch_srcs", 32'({alu_src_a, alu_src_b, alu_control, result_src}), 32'b00_10_000_10);
    cyc();
    check("add_s1", 32'(state), 32'd1);
    check("add_dec_sel", 32'({alu_src_a, alu_src_b, imm_src}), 32'b01_01_010);
    cyc();
    check("add_s2", 32'(state), 32'd6);
    check("add_exec", 32'({reg_write, alu_src_a, alu_src_b, alu_control}), 32'b0_10_00_000);
    cyc();
    check("add_s3", 32'(state), 32'd8);
    check("add_wb", 32'({reg_write, result_src}), 32'b1_00);
    cyc();
    check("add_s4", 32'(state), 32'd0);

    // bne not-zero: taken
    instr = 32'h00209463; alu_zero = 1'b0;
    cyc(); check("bne_dec", 32'(state), 32'd1);
    cyc(); check("bne_br", 32'(state), 32'd9);
    check("bne_taken", 32'({pc_write, alu_control}), 32'b1_001);
    cyc(); check("bne_back", 32'(state), 32'd0);
    // bne zero: not taken
    alu_zero = 1'b1;
    cyc(); cyc();
    check("bne_nt", 32'({state, pc_write, alu_control}), 32'b1001_0_001);
    cyc(); check("bne_nt_back", 32'(state), 32'd0);

    // bgeu with alu_zero=1: taken
    instr = 32'h0020F463;
    cyc(); cyc();
    check("bgeu", 32'({state, pc_write, alu_control}), 32'b1001_1_011);
    cyc();

    // lbu with 3 wait cycles in MEMRD
    instr = 32'h0000C183; alu_zero = 1'b0;
    cyc(); check("lbu_dec", 32'(state), 32'd1);
    mem_ready = 1'b0;
    cyc(); check("lbu_adr", 32'({state, alu_src_a, alu_src_b, imm_src}), 32'b0010_10_01_000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("lbu_wait", 32'({state, mem_req, iord, mem_we}), 32'b0011_1_1_0);
    end
    mem_ready = 1'b1; #1;
    check("lbu_ready", 32'({state, mem_req, iord}), 32'b0011_1_1);
    cyc(); check("lbu_wb", 32'({state, reg_write, result_src}), 32'b0100_1_01);
    cyc(); check("lbu_back", 32'(state), 32'd0);

    // sb: MEMADR uses S immediate, MEMWR strobes write
    instr = 32'h00308023;
    cyc(); cyc();
    check("sb_adr", 32'({state, imm_src}), 32'b0010_001);
    cyc();
    check("sb_wr", 32'({state, mem_req, mem_we, iord}), 32'b0101_1_1_1);
    cyc(); check("sb_back", 32'(state), 32'd0);

    // jal
    instr = 32'h0000006F;
    cyc(); cyc();
    check("jal", 32'({state, reg_write, result_src, imm_src}), 32'b1010_1_11_100);
    cyc(); check("jump", 32'({state, pc_write}), 32'b1100_1);
    cyc(); check("jal_back", 32'(state), 32'd0);

    // lui goes through EXEC_I with pass-B
    instr = 32'h123451B7;
    cyc(); cyc();
    check("lui", 32'({state, imm_src, alu_control}), 32'b0111_011_010);
    cyc(); cyc();

    // reset while waiting in MEMRD
    instr = 32'h0000C183;
    cyc(); mem_ready = 1'b0; cyc(); cyc();
    check("pre_rst_memrd", 32'(state), 32'd3);
    rst = 1'b1; #1;
    check("rst_mid_state", 32'({state, mem_req, iord, reg_write}), 32'b0000_1_0_0);
`ifdef PERF_COUNTERS_EN
    check("rst_mid_cnt", cycle_count | instret, 32'd0);
`endif
    cyc();

    // illegal all-zero encoding after release
    rst = 1'b0; instr = 32'h0; mem_ready = 1'b1;
    cyc();
    check("ill_pulse", 32'({state, illegal, reg_write, mem_we}), 32'b0001_1_0_0);
    cyc();
    check("ill_back", 32'({state, illegal}), 32'b0000_0);
`ifdef PERF_COUNTERS_EN
    check("ill_instret", instret, 32'd1);
    check("ill_cycles", cycle_count, 32'd2);
`endif

    // watchdog with MEM_TIMEOUT=4 and memory never ready
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("wd_not_yet", 32'({w2_state, w2_mem_req}), 32'b0000_1);
    cyc();
    check("wd_halt", 32'({w2_state, w2_halted, w2_mem_req}), 32'b1111_1_0);
    stayed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (w2_state !== 4'd15 || w2_halted !== 1'b1 || w2_mem_req !== 1'b0) stayed = 1'b0;
    end
    check("wd_stays", 32'(stayed), 32'd1);
    rst2 = 1'b1; #1;
    check("wd_rst_exit", 32'({w2_state, w2_halted, w2_mem_req}), 32'b0000_0_1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing FSM for the multi-cycle RV32I-subset core (add, addi, lbu, sb, lui, bne, bgeu, jal, jalr) with one shared instruction/data memory port. It decodes the latched instruction register, drives per-state datapath selects and enables, and handshakes with memory through mem_req/mem_ready. A watchdog halts the core if memory stops responding.

## Interface
- MEM_TIMEOUT, 255: cycles a memory request may wait without mem_ready before halting. Range 1..255; 8-bit counter.
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr  in  32  IR output; opcode [6:0], funct3 [14:12], funct7 [31:25]
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory accepts a write or returns read data this cycle; datapath latches IR/MDR when it is high
- mem_req / mem_we  out  1 / 1  memory request / write strobe (sb)
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR; the same strobe loads OldPC ← PC
- pc_write  out  1  PC ← Result
- reg_write  out  1  rd ← Result
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
- alu_control  out  3  000 = add, 001 = sub, 010 = pass B, 011 = sltu
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J
- result_src  out  2  00 = ALUOut, 01 = MDR, 10 = ALUResult (direct), 11 = PC
- illegal  out  1  one-cycle pulse on an unsupported encoding
- halted  out  1  high while the FSM is in HALT
- state  out  4  current state, for debug

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JUMP 12, HALT 15. Codes 13 and 14 go to FETCH.
- All outputs are Moore/combinational from the state, instr, alu_zero and mem_ready. Any output not listed for a state is 0.
- FETCH
  - Drives mem_req, iord=0, a=00, b=10, add, result_src=10.
  - On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay in FETCH.
- DECODE
  - Drives a=01, b=01, imm_src=010, add, so ALUOut ← branch target.
  - Next state by opcode: load or store → MEMADR; op → EXEC_R; op-imm or lui → EXEC_I; branch → BRANCH; jal → JAL; jalr → JALR.
- MEMADR: a=10, b=01, add; imm_src=000 for lbu, 001 for sb. Next is MEMRD (lbu) or MEMWR (sb).
- MEMRD: mem_req=1, iord=1; wait for mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, result_src=01, then FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; wait for mem_ready, then go to FETCH.
- EXEC_R: a=10, b=00, add.
- EXEC_I: a=10, b=01; addi uses imm_src=000 with add; lui uses imm_src=011 with pass B.
- Both EXEC states go to ALUWB. ALUWB drives reg_write=1, result_src=00, then FETCH.
- BRANCH: a=10, b=00, result_src=00.
  - bne uses sub and is taken when alu_zero=0.
  - bgeu uses sltu and is taken when alu_zero=1.
  - pc_write = taken. Next state is FETCH.
- JAL: a=01, b=01, imm_src=100, add; reg_write=1, result_src=11 (rd ← PC, i.e. OldPC+4). Next is JUMP.
- JALR: a=10, b=01, imm_src=000, add; reg_write=1, result_src=11. ALUOut latches with the pre-write rs1, so rd==rs1 is safe. Next is JUMP.
- JUMP: pc_write=1, result_src=00, then FETCH.
- Illegal encodings are checked in DECODE:
  - op with funct3≠000 or funct7≠0; op-imm with funct3≠000; load with funct3≠100; store with funct3≠000; branch with funct3 other than 001/111; jalr with funct3≠000; any other opcode.
  - Response: illegal=1 for one cycle, next state FETCH. The instruction acts as a NOP; PC is already advanced.
- Watchdog
  - An 8-bit counter increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - It clears on mem_ready, on leaving those states, and on reset.
  - If the counter equals MEM_TIMEOUT with mem_ready still 0, the next state is HALT.
- HALT: all strobes are 0 and halted=1. Only rst exits HALT.

## Timing
- Reset: state=FETCH and watchdog=0, asynchronously. Outputs therefore take their FETCH values: mem_req=1, iord=0, ir_write/pc_write/reg_write/mem_we/illegal/halted all 0.
- Reset mid-operation abandons the instruction with no further strobes.
- Latency with zero-wait memory (mem_ready=1 on the request cycle):
  - add, addi, lui, jal, jalr, sb: 4 cycles
  - lbu: 5 cycles
  - branches: 3 cycles
- Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_req, mem_we and iord hold steady for the whole wait.
- When mem_ready and the timeout threshold land on the same cycle, mem_ready wins.

## Configuration
- PERF_COUNTERS_EN defined:
  - Adds output ports cycle_count (32) and instret (32), both reset to 0 and wrapping at 2^32.
  - cycle_count increments every cycle the FSM is not in HALT.
  - instret increments on every transition into FETCH from a non-FETCH state, including illegal NOPs.
- PERF_COUNTERS_EN undefined: neither port nor its logic exists.

## Test plan
- Reset asserted in MEMRD: same cycle state=0, mem_req=1; with the macro, counters=0. After release, normal fetch.
- add x3,x1,x2 (0x002081B3), mem_ready tied 1: state sequence 0,1,6,8,0; reg_write=1 only in state 8 with result_src=00.
- bne (0x00209463) with alu_zero=0: pc_write=1, alu_control=001. Repeat with alu_zero=1: pc_write=0. Both return to FETCH after 3 cycles.
- lbu (0x0000C183), mem_ready low for 3 cycles in MEMRD: mem_req=iord=1 held 4 cycles, then MEMWB with reg_write=1 and result_src=01.
- MEM_TIMEOUT=4, mem_ready held 0 from reset: state=15 and halted=1 after 5 cycles, mem_req=0. Remains halted 100 cycles until rst.
- instr=0x00000000 in DECODE: illegal=1 for one cycle, next state 0, no reg_write or mem_we; with the macro, instret +1.
